// File: rtl/frame_bar_src.sv
// Playfield border and horizontal bar colour source with a frame-counted flash sequencer.
// The colour output is two register stages behind the x/y/state that produced it.
module frame_bar_src #(
  parameter int          X_LEFT       = 203,
  parameter int          X_RIGHT      = 435,
  parameter int          BORDER_W     = 4,
  parameter int          BAR_Y        = 181,
  parameter int          BAR_H        = 2,
  parameter logic [11:0] BORDER_RGB   = 12'hFFF,
  parameter logic [11:0] BAR_RGB      = 12'hF00,
  parameter logic [11:0] FLASH_RGB    = 12'hFFF,
  parameter int          FLASH_PERIOD = 8,
  parameter int          FLASH_COUNT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        bar_en,
  input  logic        flash_start,
  output logic        busy,
  output logic        done,
  output logic [11:0] bar_rgb
);

  localparam logic [10:0] BL_LO    = 11'(X_LEFT);
  localparam logic [10:0] BL_HI    = 11'(X_LEFT + BORDER_W - 1);
  localparam logic [10:0] BR_LO    = 11'(X_RIGHT - BORDER_W + 1);
  localparam logic [10:0] BR_HI    = 11'(X_RIGHT);
  localparam logic [10:0] BAR_X_LO = 11'(X_LEFT + BORDER_W);
  localparam logic [10:0] BAR_X_HI = 11'(X_RIGHT - BORDER_W);
  localparam logic [10:0] BAR_Y_LO = 11'(BAR_Y);
  localparam logic [10:0] BAR_Y_HI = 11'(BAR_Y + BAR_H - 1);

  localparam int PW = $clog2(FLASH_PERIOD) + 1;
  localparam int CW = $clog2(FLASH_COUNT) + 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_PERIOD - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(FLASH_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   on_cnt_q, on_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            prev_origin_q, prev_origin_d;
  logic [11:0]     stage1_q, stage1_d;
  logic [11:0]     stage2_q, stage2_d;

  logic            origin;
  logic            frame_tick;
  logic            in_border;
  logic            in_bar;

  // A held origin coordinate produces a single tick on its first cycle.
  always_comb begin
    origin        = (x == 11'd0) && (y == 11'd0);
    frame_tick    = origin && !prev_origin_q;
    prev_origin_d = origin;
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    on_cnt_d = on_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flash_start) begin
          state_d  = ST_ON;
          phase_d  = '0;
          on_cnt_d = '0;
        end
      end
      ST_ON: begin
        if (frame_tick) begin
          if (phase_q == PHASE_LAST) begin
            phase_d  = '0;
            on_cnt_d = on_cnt_q + CW'(1);
            state_d  = ST_OFF;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      ST_OFF: begin
        if (frame_tick) begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            if (on_cnt_q < ON_LAST) begin
              state_d = ST_ON;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Border and bar regions are disjoint, so border takes precedence without conflict.
  always_comb begin
    in_border = ((x >= BL_LO) && (x <= BL_HI)) || ((x >= BR_LO) && (x <= BR_HI));
    in_bar    = (x >= BAR_X_LO) && (x <= BAR_X_HI) && (y >= BAR_Y_LO) && (y <= BAR_Y_HI);
    stage1_d  = 12'h000;
    if (in_border) begin
      stage1_d = BORDER_RGB;
    end else if (in_bar) begin
      case (state_q)
        ST_ON:   stage1_d = FLASH_RGB;
        ST_OFF:  stage1_d = 12'h000;
        default: stage1_d = bar_en ? BAR_RGB : 12'h000;
      endcase
    end
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      on_cnt_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      prev_origin_q <= 1'b0;
      stage1_q      <= 12'h000;
      stage2_q      <= 12'h000;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      on_cnt_q      <= on_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      prev_origin_q <= prev_origin_d;
      stage1_q      <= stage1_d;
      stage2_q      <= stage2_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bar_rgb = stage2_q;

endmodule

// File: tb/tb_frame_bar_src.sv
// Randomized bench for frame_bar_src: a tick-count reference model predicts busy, done and colour.
module tb_frame_bar_src;
  localparam int P  = 2;
  localparam int C  = 2;
  localparam int XL = 203;
  localparam int XR = 435;
  localparam int BW = 4;
  localparam int BY = 181;
  localparam int BH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        bar_en, flash_start;
  logic        busy, done;
  logic [11:0] bar_rgb;

  int checks   = 0;
  int failures = 0;

  // Reference model: a flash is just "ticks since start"; phase = ticks / P, ON when even.
  bit          m_busy, m_done, m_prev_origin;
  int          m_ticks;
  logic [11:0] m_p1, m_p2;

  frame_bar_src #(.FLASH_PERIOD(P), .FLASH_COUNT(C)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .bar_en(bar_en),
    .flash_start(flash_start), .busy(busy), .done(done), .bar_rgb(bar_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_pixel(int px, int py, bit bsy, int ticks, bit en);
    if ((px >= XL && px <= XL + BW - 1) || (px >= XR - BW + 1 && px <= XR)) return 12'hFFF;
    if (px >= XL + BW && px <= XR - BW && py >= BY && py <= BY + BH - 1) begin
      if (bsy) return (((ticks / P) % 2) == 0) ? 12'hFFF : 12'h000;
      return en ? 12'hF00 : 12'h000;
    end
    return 12'h000;
  endfunction

  // Advance DUT and model by one clock with the currently driven inputs; no checking here.
  task automatic step();
    bit          origin, tick;
    logic [11:0] pix;
    origin = (x == 0) && (y == 0);
    tick   = origin && !m_prev_origin;
    pix    = ref_pixel(int'(x), int'(y), m_busy, m_ticks, bar_en);
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_done = 0; m_ticks = 0; m_prev_origin = 0; m_p1 = 0; m_p2 = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (flash_start) begin
          m_busy  = 1;
          m_ticks = 0;
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == 2 * P * C) begin
          m_busy  = 0;
          m_done  = 1;
          m_ticks = 0;
        end
      end
      m_prev_origin = origin;
      m_p2 = m_p1;
      m_p1 = pix;
    end
    #1;
  endtask

  task automatic rand_pixel();
    case ($urandom_range(0, 5))
      0:       x = 11'($urandom_range(XL, XL + BW - 1));
      1:       x = 11'($urandom_range(XR - BW + 1, XR));
      2, 3:    x = 11'($urandom_range(XL + BW, XR - BW));
      4:       x = 11'($urandom_range(1, XL - 1));
      default: x = 11'($urandom_range(XR + 1, 1500));
    endcase
    y = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1, 400)) : 11'($urandom_range(BY - 1, BY + BH));
  endtask

  task automatic test_reset();
    reset = 1; flash_start = 1; bar_en = 1; x = 11'd210; y = 11'd181;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, done, bar_rgb} !== {m_busy, m_done, m_p2} || bar_rgb !== 12'h000) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got busy=%b done=%b rgb=%h want busy=%b done=%b rgb=%h",
                 i, busy, done, bar_rgb, m_busy, m_done, m_p2);
      end
    end
    $display("test_reset: 3 reset cycles");
  endtask

  task automatic test_pixels();
    int          px[3] = '{204, 206, 207};
    int          py[3] = '{181, 181, 183};
    logic [11:0] want[3] = '{12'hFFF, 12'hFFF, 12'h000};
    reset = 0; flash_start = 0; bar_en = 1; x = 11'd210; y = 11'd181;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (bar_rgb !== m_p2 || (i >= 2 && bar_rgb !== 12'hF00)) begin
        failures++;
        $display("FAIL bar_after_reset clk=%0d got rgb=%h want rgb=%h", i, bar_rgb, m_p2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      x = 11'(px[k]); y = 11'(py[k]);
      step(); step();
      checks++;
      if (bar_rgb !== want[k] || bar_rgb !== m_p2) begin
        failures++;
        $display("FAIL pixel_%0d_%0d got rgb=%h want rgb=%h", px[k], py[k], bar_rgb, want[k]);
      end
      $display("pixel x=%0d y=%0d rgb=%h", px[k], py[k], bar_rgb);
    end
  endtask

  task automatic test_random_idle();
    reset = 0; flash_start = 0;
    for (int i = 0; i < 60; i++) begin
      rand_pixel();
      bar_en = 1'($urandom_range(0, 1));
      step();
      checks++;
      if ({busy, done, bar_rgb} !== {m_busy, m_done, m_p2}) begin
        failures++;
        $display("FAIL idle_random cyc=%0d got busy=%b done=%b rgb=%h want busy=%b done=%b rgb=%h",
                 i, busy, done, bar_rgb, m_busy, m_done, m_p2);
      end
    end
    $display("test_random_idle: 60 cycles");
  endtask

  task automatic test_flash_sequence(input bit start_on_tick, input bit restart);
    int dones = 0;
    int after = -1;
    int flen;
    reset = 0; bar_en = 1'($urandom_range(0, 1));
    rand_pixel(); flash_start = 0;
    step();
    if (start_on_tick) begin x = 11'd0; y = 11'd0; end else rand_pixel();
    flash_start = 1;
    step();
    checks++;
    if (busy !== 1'b1 || busy !== m_busy) begin
      failures++;
      $display("FAIL flash_start_accept got busy=%b want busy=1", busy);
    end
    for (int f = 0; f < 20 && after != 0; f++) begin
      flen = $urandom_range(3, 5);
      for (int i = 0; i < flen; i++) begin
        if (i == 0) begin x = 11'd0; y = 11'd0; end else rand_pixel();
        flash_start = restart && m_busy && ($urandom_range(0, 2) == 0);
        step();
        if (done === 1'b1) dones++;
        checks++;
        if ({busy, done, bar_rgb} !== {m_busy, m_done, m_p2}) begin
          failures++;
          $display("FAIL flash_seq frame=%0d cyc=%0d got busy=%b done=%b rgb=%h want busy=%b done=%b rgb=%h",
                   f, i, busy, done, bar_rgb, m_busy, m_done, m_p2);
        end
      end
      if (after > 0) after--;
      if (after < 0 && dones > 0) after = 2;
    end
    flash_start = 0;
    checks++;
    if (dones !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flash_done_count got dones=%0d busy=%b want dones=1 busy=0", dones, busy);
    end
    $display("flash sequence start_on_tick=%0d restart=%0d dones=%0d", start_on_tick, restart, dones);
  endtask

  task automatic test_held_origin();
    reset = 0; bar_en = 1; flash_start = 1; x = 11'd300; y = 11'd181;
    step();
    flash_start = 0;
    for (int h = 0; h < 2; h++) begin
      x = 11'd0; y = 11'd0;
      repeat (5) step();
      x = 11'd300; y = 11'd181;
      repeat (3) step();
    end
    checks++;
    if (busy !== 1'b1 || bar_rgb !== 12'h000 || {busy, bar_rgb} !== {m_busy, m_p2}) begin
      failures++;
      $display("FAIL held_origin got busy=%b rgb=%h want busy=1 rgb=000", busy, bar_rgb);
    end
    $display("held origin: busy=%b rgb=%h ticks=%0d", busy, bar_rgb, m_ticks);
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    reset = 0; bar_en = 1; flash_start = 1; x = 11'd300; y = 11'd181;
    step();
    flash_start = 0; x = 11'd0; y = 11'd0;
    step();
    x = 11'd300; y = 11'd181;
    step(); step();
    checks++;
    if (busy !== 1'b1 || bar_rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL abort_pre_on got busy=%b rgb=%h want busy=1 rgb=fff", busy, bar_rgb);
    end
    reset = 1; flash_start = 1;
    step();
    reset = 0; flash_start = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got busy=%b done=%b want busy=0 done=0", busy, done);
    end
    step(); step();
    checks++;
    if (bar_rgb !== 12'hF00 || bar_rgb !== m_p2) begin
      failures++;
      $display("FAIL abort_bar_restore got rgb=%h want rgb=f00", bar_rgb);
    end
    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 0) begin x = 11'd0; y = 11'd0; end else rand_pixel();
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got dones=%0d busy=%b want dones=0 busy=0", dones, busy);
    end
    $display("reset abort: dones=%0d", dones);
  endtask

  initial begin
    reset = 1; x = '0; y = '0; bar_en = 0; flash_start = 0;
    m_busy = 0; m_done = 0; m_prev_origin = 0; m_ticks = 0; m_p1 = 0; m_p2 = 0;
    test_reset();
    test_pixels();
    test_random_idle();
    test_flash_sequence(1'b0, 1'b0);
    test_flash_sequence(1'b1, 1'b0);
    test_flash_sequence(1'b0, 1'b1);
    test_held_origin();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_bar_src.md
FRAME_BAR_SRC -- requirements
Module: frame_bar_src

Interface
REQ-001 Parameter X_LEFT, default 203, leftmost column of the left playfield border.
REQ-002 Parameter X_RIGHT, default 435, rightmost column of the right playfield border.
REQ-003 Parameter BORDER_W, default 4, border thickness in pixels (columns X_LEFT..X_LEFT+BORDER_W-1 and X_RIGHT-BORDER_W+1..X_RIGHT).
REQ-004 Parameter BAR_Y, default 181, first row of the horizontal bar.
REQ-005 Parameter BAR_H, default 2, bar height in rows (BAR_Y..BAR_Y+BAR_H-1).
REQ-006 Parameter BORDER_RGB, default 12'hFFF; BAR_RGB, default 12'hF00; FLASH_RGB, default 12'hFFF.
REQ-007 Parameter FLASH_PERIOD, default 8, frames per flash phase (>=1); FLASH_COUNT, default 3, ON phases per flash sequence (>=1).
REQ-008 clk  input  1  system clock; all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 x  input  11  current pixel column.
REQ-011 y  input  11  current pixel row.
REQ-012 bar_en  input  1  level; bar drawn in normal colour when high and no flash active.
REQ-013 flash_start  input  1  single-cycle request to start a flash sequence.
REQ-014 busy  output  1  high while a flash sequence is in progress.
REQ-015 done  output  1  one-cycle pulse when a flash sequence completes.
REQ-016 bar_rgb  output  12  pixel colour {r[3:0], g[3:0], b[3:0]}.

Function
REQ-017 Border region: X_LEFT<=x<=X_LEFT+BORDER_W-1 or X_RIGHT-BORDER_W+1<=x<=X_RIGHT, any y -> BORDER_RGB.
REQ-018 Bar region: X_LEFT+BORDER_W<=x<=X_RIGHT-BORDER_W and BAR_Y<=y<=BAR_Y+BAR_H-1; regions are disjoint by construction.
REQ-019 Bar region colour: FLASH_ON state -> FLASH_RGB; FLASH_OFF state -> 12'h000; IDLE -> BAR_RGB if bar_en else 12'h000.
REQ-020 All other pixels -> 12'h000; all comparisons unsigned, 11-bit.
REQ-021 Colour path: two register stages; bar_rgb reflects x/y/state sampled 2 clocks earlier.
REQ-022 Frame tick: registered flag prev_origin = (x==0 && y==0); frame_tick = (x==0 && y==0) && !prev_origin, so a held origin coordinate yields exactly one tick.
REQ-023 States: IDLE, FLASH_ON, FLASH_OFF; busy = (state != IDLE), driven from register.
REQ-024 IDLE -> FLASH_ON on flash_start; phase counter and ON counter cleared to 0.
REQ-025 flash_start while busy: ignored, no effect on counters or state.
REQ-026 Phase counter increments on frame_tick; at FLASH_PERIOD-1 with frame_tick it clears and the phase ends.
REQ-027 FLASH_ON phase end -> FLASH_OFF, ON counter += 1.
REQ-028 FLASH_OFF phase end: ON counter < FLASH_COUNT -> FLASH_ON; ON counter == FLASH_COUNT -> IDLE with done=1 for that one cycle.
REQ-029 flash_start coincident with frame_tick in IDLE: start accepted; that tick not counted.
REQ-030 Counter widths sized by $clog2 of their limits +1; no wrap permitted before terminal value.

Reset
REQ-031 On reset: state IDLE, both counters 0, prev_origin 0, busy 0, done 0, both colour stages 12'h000 (bar_rgb 12'h000 next cycle).
REQ-032 Reset mid-sequence aborts it: no done pulse, flash_start in the same cycle as reset ignored.

Verification
REQ-033 Reset, x=210,y=181,bar_en=1, 3 clocks -> bar_rgb 12'hF00 from the 2nd clock after reset release; x=204 -> 12'hFFF; x=206,y=181 -> 12'hFFF; x=207,y=183 -> 12'h000.
REQ-034 FLASH_PERIOD=2, FLASH_COUNT=2: flash_start, then 8 frame ticks -> states ON,ON,OFF,OFF,ON,ON,OFF,OFF per tick pair; done pulses once after 8th tick; busy falls same cycle.
REQ-035 Hold x=0,y=0 for 5 clocks -> exactly one frame_tick counted (phase counter +1).
REQ-036 flash_start pulsed again during FLASH_OFF -> sequence length unchanged, single done.
REQ-037 Reset asserted in FLASH_ON -> next cycle busy=0, done never pulses, bar returns to BAR_RGB with bar_en=1 after 2 clocks.
